// File: rtl/jk_mod_counter_jk_cell.sv
// jk_cell: single-bit rising-edge JK flip-flop with asynchronous active-high reset.
// Ports: clk, rst (async, active-high), j, k (00 hold, 01 clear, 10 set, 11 toggle),
//        q (state), q_bar (~q).
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  logic state_q;
  logic state_d;

  always_comb begin
    state_d = state_q;
    unique case ({j, k})
      2'b00:   state_d = state_q;
      2'b01:   state_d = 1'b0;
      2'b10:   state_d = 1'b1;
      default: state_d = ~state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q     = state_q;
  assign q_bar = ~state_q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS up/down counter built from WIDTH JK cells.
// Ports: clk, rst (async, active-high), clr_bar (sync clear, active-low), ld/d (sync load),
//        en/up (count enable/direction), q/q_bar (count), tc (comb terminal count), wrap (registered pulse).
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_bar,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  // One extra bit so the ">= MAXV" test never degenerates into a constant
  // comparison when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MAXV_W = {1'b0, MAXV};

  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] nxt_d;
  logic             wrap_d;
  logic             wrap_q;
  logic             at_top;
  logic             at_zero;

  // Loaded values above MAXV count as "at top", so an up-count wraps them to 0.
  assign at_top  = ({1'b0, q} >= MAXV_W);
  assign at_zero = (q == '0);

  always_comb begin
    nxt_d  = q;
    wrap_d = 1'b0;
    if (!clr_bar) begin
      nxt_d = '0;
    end else if (ld) begin
      nxt_d = d;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          nxt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          nxt_d = q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          nxt_d  = MAXV;
          wrap_d = 1'b1;
        end else begin
          nxt_d = q - 1'b1;
        end
      end
    end
  end

  // Each cell is driven in set/reset form so it simply captures nxt_d.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .j     (nxt_d[i]),
      .k     (~nxt_d[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
  assign tc   = en & (up ? at_top : at_zero);

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_bar = 1'b1;
  logic       ld = 1'b0;
  logic [3:0] d = 4'h0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic [3:0] q;
  logic [3:0] q_bar;
  logic       tc;
  logic       wrap;

  // cascade pair (MODULUS 16)
  logic       c_ld = 1'b0;
  logic       c_en = 1'b0;
  logic [3:0] c_dlo = 4'h0;
  logic [3:0] c_dhi = 4'h0;
  logic [3:0] lo_q, lo_qb, hi_q, hi_qb;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .clr_bar(clr_bar), .ld(ld), .d(d), .en(en), .up(up),
    .q(q), .q_bar(q_bar), .tc(tc), .wrap(wrap)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
    .clk(clk), .rst(rst), .clr_bar(1'b1), .ld(c_ld), .d(c_dlo), .en(c_en), .up(1'b1),
    .q(lo_q), .q_bar(lo_qb), .tc(lo_tc), .wrap(lo_wrap)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
    .clk(clk), .rst(rst), .clr_bar(1'b1), .ld(c_ld), .d(c_dhi), .en(lo_tc), .up(1'b1),
    .q(hi_q), .q_bar(hi_qb), .tc(hi_tc), .wrap(hi_wrap)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL reset_q got=%0h exp=0", q); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%0b exp=0", wrap); end
    checks++;
    if (q_bar !== 4'hF) begin errors++; $display("FAIL reset_qbar got=%0h exp=F", q_bar); end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] eq;
    en = 1'b1; up = 1'b1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_start got=%0b exp=0", tc); end
    for (int i = 0; i < 12; i++) begin
      tick();
      eq = 4'((i + 1) % 10);
      checks++;
      if (q !== eq) begin errors++; $display("FAIL up_q step=%0d got=%0h exp=%0h", i, q, eq); end
      checks++;
      if (wrap !== (eq == 4'd0)) begin
        errors++; $display("FAIL up_wrap step=%0d got=%0b exp=%0b", i, wrap, eq == 4'd0);
      end
      checks++;
      if (tc !== (eq == 4'd9)) begin
        errors++; $display("FAIL up_tc step=%0d got=%0b exp=%0b", i, tc, eq == 4'd9);
      end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q [4] = '{4'd9, 4'd8, 4'd7, 4'd6};
    clr_bar = 1'b0;
    tick();
    clr_bar = 1'b1;
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL clr_q got=%0h exp=0", q); end
    up = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL down_tc_at0 got=%0b exp=1", tc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i]) begin errors++; $display("FAIL down_q step=%0d got=%0h exp=%0h", i, q, exp_q[i]); end
      checks++;
      if (wrap !== (i == 0)) begin errors++; $display("FAIL down_wrap step=%0d got=%0b exp=%0b", i, wrap, i == 0); end
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL down_tc step=%0d got=%0b exp=0", i, tc); end
    end
  endtask

  task automatic test_load_over_modulus();
    logic [3:0] exp_q [3] = '{4'hB, 4'hA, 4'h9};
    ld = 1'b1; d = 4'hC; en = 1'b1; up = 1'b1;
    tick();
    ld = 1'b0;
    #1;
    checks++;
    if (q !== 4'hC) begin errors++; $display("FAIL load_q got=%0h exp=C", q); end
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL load_tc got=%0b exp=1", tc); end
    tick();
    checks++;
    if (q !== 4'h0) begin errors++; $display("FAIL load_up_wrap_q got=%0h exp=0", q); end
    checks++;
    if (wrap !== 1'b1) begin errors++; $display("FAIL load_up_wrap got=%0b exp=1", wrap); end
    ld = 1'b1; d = 4'hC; up = 1'b0;
    tick();
    ld = 1'b0;
    checks++;
    if (q !== 4'hC) begin errors++; $display("FAIL load2_q got=%0h exp=C", q); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i]) begin errors++; $display("FAIL load_down_q step=%0d got=%0h exp=%0h", i, q, exp_q[i]); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL load_down_wrap step=%0d got=%0b exp=0", i, wrap); end
    end
  endtask

  task automatic test_priority();
    clr_bar = 1'b0; ld = 1'b1; en = 1'b1; d = 4'd7; up = 1'b1;
    tick();
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL prio_clr_q got=%0h exp=0", q); end
    clr_bar = 1'b1; d = 4'd5;
    tick();
    checks++;
    if (q !== 4'd5) begin errors++; $display("FAIL prio_ld_q got=%0h exp=5", q); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL prio_ld_wrap got=%0b exp=0", wrap); end
    ld = 1'b0; en = 1'b0;
    tick();
    checks++;
    if (q !== 4'd5) begin errors++; $display("FAIL hold_q got=%0h exp=5", q); end
  endtask

  task automatic test_async_reset();
    ld = 1'b1; d = 4'd7;
    tick();
    ld = 1'b0; en = 1'b0;
    checks++;
    if (q !== 4'd7) begin errors++; $display("FAIL arst_pre_q got=%0h exp=7", q); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL arst_q got=%0h exp=0", q); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL arst_wrap got=%0b exp=0", wrap); end
    #2 rst = 1'b0;
    en = 1'b1; up = 1'b1;
    tick();
    checks++;
    if (q !== 4'd1) begin errors++; $display("FAIL arst_resume_q got=%0h exp=1", q); end
    checks++;
    if (q_bar !== 4'hE) begin errors++; $display("FAIL arst_qbar got=%0h exp=E", q_bar); end
    en = 1'b0;
  endtask

  task automatic test_cascade();
    c_ld = 1'b1; c_dlo = 4'hE; c_dhi = 4'hF;
    tick();
    c_ld = 1'b0; c_en = 1'b1;
    checks++;
    if ({hi_q, lo_q} !== 8'hFE) begin errors++; $display("FAIL casc_load got=%0h exp=FE", {hi_q, lo_q}); end
    tick();
    checks++;
    if ({hi_q, lo_q} !== 8'hFF) begin errors++; $display("FAIL casc_ff got=%0h exp=FF", {hi_q, lo_q}); end
    tick();
    checks++;
    if ({hi_q, lo_q} !== 8'h00) begin errors++; $display("FAIL casc_wrap_q got=%0h exp=00", {hi_q, lo_q}); end
    checks++;
    if ({hi_wrap, lo_wrap} !== 2'b11) begin
      errors++; $display("FAIL casc_wrap got=%0b%0b exp=11", hi_wrap, lo_wrap);
    end
    tick();
    checks++;
    if ({hi_q, lo_q} !== 8'h01 || {hi_wrap, lo_wrap} !== 2'b00) begin
      errors++; $display("FAIL casc_after got=%0h/%0b%0b exp=01/00", {hi_q, lo_q}, hi_wrap, lo_wrap);
    end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_over_modulus();
    test_priority();
    test_async_reset();
    test_cascade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
